fc_lanes: RTL and testbench

Parametrised fully-connected forward layer: a streamed-input Q-format MAC engine with LANES parallel output neurons, on-chip weight and bias memory, saturating output and optional ReLU. It is the next generation of the single-lane `fc` layer. It sits between a producer of flattened activations (conv/pool output or a previous `fc_lanes`) and the next layer or classifier. It holds one input vector and replays it against N_OUT/LANES weight groups.

---
 rtl/fc_lanes.sv | 224 ++++++++++++++++++++++
 tb/tb_fc_lanes.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_lanes.sv
// Fully-connected forward layer: holds one input vector and replays it against
// N_OUT/LANES weight groups, LANES Q-format MAC lanes in parallel, saturating output.
module fc_lanes #(
  parameter int unsigned N_IN   = 1024,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned RELU   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_weights,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_rdy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rdy,
  output logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx
);

  localparam int unsigned GROUPS   = N_OUT / LANES;
  localparam int unsigned DEPTH    = GROUPS * N_IN;
  localparam int unsigned ROW_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ROW_P2   = 2 ** ROW_W;
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LANES_P2 = 2 ** LANE_W;
  localparam int unsigned GRP_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned CNT_W    = IDX_W + 1;
  localparam int unsigned W_WORDS  = N_OUT * N_IN;
  localparam int unsigned TOTAL    = W_WORDS + N_OUT;
  localparam int unsigned WCNT_W   = $clog2(TOTAL + 1);
  localparam int unsigned ACC_W    = DATA_W + IDX_W;
  localparam int unsigned PROD_W   = 2 * DATA_W;
  localparam int unsigned SUM_W    = ACC_W + 1;
  localparam int unsigned IDX_P2   = 2 ** IDX_W;

  typedef enum logic [1:0] {S_GATHER, S_LOAD, S_MAC, S_EMIT} state_t;

  state_t state;

  logic [IDX_W-1:0]  in_cnt;
  logic [WCNT_W-1:0] wcnt;
  logic [IDX_W-1:0]  w_i;
  logic [LANE_W-1:0] w_lane;
  logic [ROW_W-1:0]  w_row;
  logic [GRP_W-1:0]  group;
  logic [ROW_W-1:0]  grp_row;
  logic [IDX_W-1:0]  grp_idx;
  logic [CNT_W-1:0]  mcnt;
  logic [LANE_W-1:0] lane;

  logic signed [ACC_W-1:0]  acc  [LANES_P2];
  logic signed [ACC_W-1:0]  term [LANES_P2];
  logic signed [DATA_W-1:0] w_q  [LANES_P2];
  logic signed [DATA_W-1:0] x_q;

  logic [DATA_W-1:0] xbuf [IDX_P2];
  logic [DATA_W-1:0] bmem [IDX_P2];
  logic [DATA_W-1:0] wmem [LANES_P2][ROW_P2];

  logic              w_is_weight;
  logic [IDX_W-1:0]  b_idx;
  logic [ROW_W-1:0]  rd_row;
  logic [LANE_W-1:0] emit_lane;
  logic [IDX_W-1:0]  emit_idx;
  logic [DATA_W-1:0] res_c;

  assign in_rdy = (state == S_GATHER) && !load_weights;
  assign w_rdy  = (state == S_LOAD);
  assign in_idx = in_cnt;

  assign w_is_weight = wcnt < WCNT_W'(W_WORDS);
  assign b_idx       = IDX_W'(wcnt - WCNT_W'(W_WORDS));
  assign rd_row      = grp_row + ROW_W'(mcnt);
  // Lane being presented next: current lane when idle, following lane on a handshake.
  assign emit_lane   = out_valid ? lane + LANE_W'(1) : lane;
  assign emit_idx    = grp_idx + IDX_W'(emit_lane);

  function automatic logic [DATA_W-1:0] sat_relu(input logic signed [ACC_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
    logic signed [SUM_W-1:0] s;
    logic [DATA_W-1:0]       r;
    s = {a[ACC_W-1], a} + {{(SUM_W-DATA_W){b[DATA_W-1]}}, b};
    if ((&s[SUM_W-1:DATA_W-1]) || !(|s[SUM_W-1:DATA_W-1])) r = s[DATA_W-1:0];
    else if (s[SUM_W-1])                                    r = {1'b1, {(DATA_W-1){1'b0}}};
    else                                                    r = {1'b0, {(DATA_W-1){1'b1}}};
    if (RELU != 0 && r[DATA_W-1]) r = '0;
    return r;
  endfunction

  assign res_c = sat_relu(acc[emit_lane], bmem[emit_idx]);

  // Per-lane Q-format product; arithmetic shift truncates toward minus infinity.
  always_comb begin
    for (int l = 0; l < LANES_P2; l++) begin
      term[l] = ACC_W'((PROD_W'(w_q[l]) * PROD_W'(x_q)) >>> FRAC_W);
    end
  end

  // Memories and read pipeline; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state == S_GATHER && in_valid && in_rdy) xbuf[in_cnt] <= in_data;
    if (state == S_LOAD && w_valid) begin
      if (w_is_weight) wmem[w_lane][w_row + ROW_W'(w_i)] <= w_data;
      else             bmem[b_idx] <= w_data;
    end
    if (state == S_MAC) begin
      x_q <= xbuf[IDX_W'(mcnt)];
      for (int l = 0; l < LANES_P2; l++) w_q[l] <= wmem[LANE_W'(l)][rd_row];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_GATHER;
      in_cnt    <= '0;
      wcnt      <= '0;
      w_i       <= '0;
      w_lane    <= '0;
      w_row     <= '0;
      group     <= '0;
      grp_row   <= '0;
      grp_idx   <= '0;
      mcnt      <= '0;
      lane      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      for (int l = 0; l < LANES_P2; l++) acc[l] <= '0;
    end else begin
      case (state)
        S_GATHER: begin
          if (in_valid && in_rdy) begin
            if (in_cnt == IDX_W'(N_IN - 1)) begin
              state   <= S_MAC;
              in_cnt  <= '0;
              group   <= '0;
              grp_row <= '0;
              grp_idx <= '0;
              mcnt    <= '0;
              for (int l = 0; l < LANES_P2; l++) acc[l] <= '0;
            end else begin
              in_cnt <= in_cnt + IDX_W'(1);
            end
          end else if (load_weights && in_cnt == '0) begin
            state  <= S_LOAD;
            wcnt   <= '0;
            w_i    <= '0;
            w_lane <= '0;
            w_row  <= '0;
          end
        end
        S_LOAD: begin
          if (w_valid) begin
            if (wcnt == WCNT_W'(TOTAL - 1)) begin
              state <= S_GATHER;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + WCNT_W'(1);
            end
            // Walk weight o = (row-group, lane) and index i in row-major order.
            if (w_is_weight) begin
              if (w_i == IDX_W'(N_IN - 1)) begin
                w_i <= '0;
                if (w_lane == LANE_W'(LANES - 1)) begin
                  w_lane <= '0;
                  w_row  <= w_row + ROW_W'(N_IN);
                end else begin
                  w_lane <= w_lane + LANE_W'(1);
                end
              end else begin
                w_i <= w_i + IDX_W'(1);
              end
            end
          end
        end
        S_MAC: begin
          mcnt <= mcnt + CNT_W'(1);
          if (mcnt != '0) begin
            for (int l = 0; l < LANES_P2; l++) acc[l] <= acc[l] + term[l];
          end
          if (mcnt == CNT_W'(N_IN)) begin
            state <= S_EMIT;
            lane  <= '0;
          end
        end
        S_EMIT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= res_c;
            out_idx   <= emit_idx;
          end else if (out_rdy) begin
            if (lane == LANE_W'(LANES - 1)) begin
              out_valid <= 1'b0;
              if (group == GRP_W'(GROUPS - 1)) begin
                state <= S_GATHER;
              end else begin
                state   <= S_MAC;
                group   <= group + GRP_W'(1);
                grp_row <= grp_row + ROW_W'(N_IN);
                grp_idx <= grp_idx + IDX_W'(LANES);
                mcnt    <= '0;
                for (int l = 0; l < LANES_P2; l++) acc[l] <= '0;
              end
            end else begin
              lane     <= emit_lane;
              out_data <= res_c;
              out_idx  <= emit_idx;
            end
          end
        end
        default: state <= S_GATHER;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_lanes.sv
// Directed bench for fc_lanes: N_IN=4, N_OUT=4, LANES=2; a RELU=0 and a RELU=1
// instance share all inputs so every result is checked in both modes.
module tb_fc_lanes;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_OUT  = 4;
  localparam int unsigned LANES  = 2;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FRAC_W = 16;
  localparam int          NVEC   = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_weights = 1'b0;
  logic              w_valid = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_rdy = 1'b1;

  logic              w_rdy, in_rdy, out_valid;
  logic [IDX_W-1:0]  in_idx, out_idx;
  logic [DATA_W-1:0] out_data;
  logic              w_rdy_r, in_rdy_r, out_valid_r;
  logic [IDX_W-1:0]  in_idx_r, out_idx_r;
  logic [DATA_W-1:0] out_data_r;

  fc_lanes #(.N_IN(N_IN), .N_OUT(N_OUT), .IDX_W(IDX_W), .DATA_W(DATA_W),
             .FRAC_W(FRAC_W), .LANES(LANES), .RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .load_weights(load_weights), .w_valid(w_valid),
    .w_data(w_data), .w_rdy(w_rdy), .in_valid(in_valid), .in_data(in_data),
    .in_rdy(in_rdy), .in_idx(in_idx), .out_valid(out_valid), .out_rdy(out_rdy),
    .out_data(out_data), .out_idx(out_idx));

  fc_lanes #(.N_IN(N_IN), .N_OUT(N_OUT), .IDX_W(IDX_W), .DATA_W(DATA_W),
             .FRAC_W(FRAC_W), .LANES(LANES), .RELU(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .load_weights(load_weights), .w_valid(w_valid),
    .w_data(w_data), .w_rdy(w_rdy_r), .in_valid(in_valid), .in_data(in_data),
    .in_rdy(in_rdy_r), .in_idx(in_idx_r), .out_valid(out_valid_r), .out_rdy(out_rdy),
    .out_data(out_data_r), .out_idx(out_idx_r));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][3:0][31:0] w;  // w[o][i]
    logic [3:0][31:0]      x;
    logic [3:0][31:0]      b;
    logic [3:0][31:0]      e;  // expected RELU=0 result per neuron
  } vec_t;

  vec_t vecs [NVEC];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
    return v[31] ? 32'h0 : v;
  endfunction

  task automatic set_uniform(input int v, input logic [31:0] w, input logic [31:0] x,
                             input logic [31:0] b, input logic [31:0] e);
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) vecs[v].w[o][i] = w;
      vecs[v].x[o] = x;
      vecs[v].b[o] = b;
      vecs[v].e[o] = e;
    end
  endtask

  task automatic load_vec(input int v);
    load_weights = 1'b1;
    tick();
    load_weights = 1'b0;
    check("w_rdy in load", {31'b0, w_rdy}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      w_valid = 1'b1;
      w_data  = (k < 16) ? vecs[v].w[k/4][k%4] : vecs[v].b[k-16];
      tick();
    end
    w_valid = 1'b0;
    check("w_rdy after load", {31'b0, w_rdy}, 32'd0);
    check("in_rdy after load", {31'b0, in_rdy}, 32'd1);
  endtask

  task automatic send_range(input int v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int n = 0;
      while (!in_rdy && n < 50) begin tick(); n++; end
      if (!in_rdy) begin
        total++; bad++;
        $display("FAIL in_rdy timeout: got 0 want 1");
      end
      in_valid = 1'b1;
      in_data  = vecs[v].x[i];
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 50) begin tick(); cnt++; end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL out_valid timeout: got 0 want 1");
    end
  endtask

  task automatic check_lane(input int v, input int n);
    check("out_idx", {22'b0, out_idx}, 32'(n));
    check("out_data", out_data, vecs[v].e[n]);
    check("relu out_valid", {31'b0, out_valid_r}, 32'd1);
    check("relu out_data", out_data_r, relu(vecs[v].e[n]));
  endtask

  // Collect all four results with out_rdy high; exp_lat < 0 skips the first-latency check.
  task automatic collect(input int v, input int exp_lat);
    int c;
    for (int n = 0; n < 4; n++) begin
      wait_out(c);
      if (n == 0 && exp_lat >= 0) check("first latency", 32'(c), 32'(exp_lat));
      if (n == 2) check("group latency", 32'(c), 32'd6);
      if (n % 2 == 1) check("lane stream gap", 32'(c), 32'd0);
      check("in_rdy low in emit", {31'b0, in_rdy}, 32'd0);
      check_lane(v, n);
      tick();
    end
  endtask

  task automatic hold_check(input int v, input int n);
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", {31'b0, out_valid}, 32'd1);
      check_lane(v, n);
      tick();
    end
    check_lane(v, n);
  endtask

  initial begin
    int c;
    set_uniform(0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0004_0000);
    set_uniform(1, 32'h0001_0000, 32'h0001_0000, 32'hFFF8_0000, 32'hFFFC_0000);
    set_uniform(2, 32'h7FFF_0000, 32'h0064_0000, 32'h0000_0000, 32'h7FFF_FFFF);
    set_uniform(3, 32'h8001_0000, 32'h0064_0000, 32'h0000_0000, 32'h8000_0000);
    set_uniform(4, 32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0005_0000);
    set_uniform(5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFC);
    set_uniform(6, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int o = 0; o < 4; o++) begin
      vecs[6].w[o][o] = 32'h0001_0000;
      vecs[6].x[o]    = 32'(o + 1) << 16;
      vecs[6].b[o]    = 32'(o) << 8;
    end
    vecs[6].e[0] = 32'h0001_0000;
    vecs[6].e[1] = 32'h0002_0100;
    vecs[6].e[2] = 32'h0003_0200;
    vecs[6].e[3] = 32'h0004_0300;

    tick();
    tick();
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst out_idx", {22'b0, out_idx}, 32'd0);
    check("rst w_rdy", {31'b0, w_rdy}, 32'd0);
    check("rst in_idx", {22'b0, in_idx}, 32'd0);
    check("rst in_rdy", {31'b0, in_rdy}, 32'd1);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < NVEC; v++) begin
      load_vec(v);
      send_range(v, 0, N_IN - 1);
      check("in_rdy after last input", {31'b0, in_rdy}, 32'd0);
      collect(v, 6);
    end

    // Backpressure on out_idx 0 and 2.
    load_vec(0);
    out_rdy = 1'b0;
    send_range(0, 0, N_IN - 1);
    wait_out(c);
    check("bp first latency", 32'(c), 32'd6);
    hold_check(0, 0);
    out_rdy = 1'b1;
    tick();
    check_lane(0, 1);
    tick();
    out_rdy = 1'b0;
    wait_out(c);
    check("bp group latency", 32'(c), 32'd6);
    hold_check(0, 2);
    out_rdy = 1'b1;
    tick();
    check_lane(0, 3);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("no extra output", {31'b0, out_valid}, 32'd0);
      tick();
    end
    check("idle in_rdy", {31'b0, in_rdy}, 32'd1);

    // Reset at cycle 2 of MAC, then resend without reloading.
    send_range(0, 0, N_IN - 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid-mac rst out_valid", {31'b0, out_valid}, 32'd0);
    check("mid-mac rst in_rdy", {31'b0, in_rdy}, 32'd1);
    check("mid-mac rst in_idx", {22'b0, in_idx}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("no output after rst", {31'b0, out_valid}, 32'd0);
      tick();
    end
    send_range(0, 0, N_IN - 1);
    collect(0, 6);

    // load_weights during MAC is ignored.
    send_range(0, 0, N_IN - 1);
    tick();
    load_weights = 1'b1;
    tick();
    check("mac load w_rdy", {31'b0, w_rdy}, 32'd0);
    check("mac load in_rdy", {31'b0, in_rdy}, 32'd0);
    load_weights = 1'b0;
    collect(0, 4);

    // load_weights in GATHER with in_cnt=2 is ignored.
    send_range(0, 0, 1);
    load_weights = 1'b1;
    #1;
    check("gather load in_rdy", {31'b0, in_rdy}, 32'd0);
    tick();
    check("gather load w_rdy", {31'b0, w_rdy}, 32'd0);
    check("gather load in_idx", {22'b0, in_idx}, 32'd2);
    load_weights = 1'b0;
    send_range(0, 2, N_IN - 1);
    collect(0, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
